act_unit: RTL

Parametrised activation stage that replaces the single-channel ReLU in the 1D-CNN datapath. It sits between a neuron/accumulator output and the next layer. It processes CHANNELS signed fixed-point lanes per beat, with a run-time selectable function: ReLU, leaky ReLU or clipped ReLU. It has a two-stage registered pipeline with full valid/ready backpressure.

---
 rtl/act_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/act_unit.sv
// Two-stage activation pipeline: stage 1 captures a beat with its own config snapshot,
// stage 2 applies bypass / ReLU / leaky ReLU / clipped ReLU per lane behind valid/ready.
module act_unit #(
    parameter int DATA_WIDTH   = 12,
    parameter int CHANNELS     = 4,
    parameter int LEAK_SHIFT_W = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     act_mode,
    input  logic [LEAK_SHIFT_W-1:0]        act_leak_shift,
    input  logic [DATA_WIDTH-1:0]          act_clip_max,
    output logic                           act_ready_in,
    input  logic                           act_valid_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] act_data_in,
    input  logic                           act_ready_out,
    output logic                           act_valid_out,
    output logic [CHANNELS*DATA_WIDTH-1:0] act_data_out
);

    localparam int BUS_W = CHANNELS * DATA_WIDTH;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_LEAKY  = 2'd2,
        MODE_CLIP   = 2'd3
    } mode_e;

    logic                    s1_valid_q;
    logic [BUS_W-1:0]        s1_data_q;
    mode_e                   s1_mode_q;
    logic [LEAK_SHIFT_W-1:0] s1_shift_q;
    logic [DATA_WIDTH-1:0]   s1_clip_q;

    logic                    s2_valid_q;
    logic [BUS_W-1:0]        s2_data_q;
    logic [BUS_W-1:0]        s2_data_d;

    logic                    s2_load;
    logic                    in_xfer;

    function automatic logic [DATA_WIDTH-1:0] act_lane(
        input logic signed [DATA_WIDTH-1:0] x,
        input mode_e                        m,
        input logic [LEAK_SHIFT_W-1:0]      sh,
        input logic signed [DATA_WIDTH-1:0] clip
    );
        logic signed [DATA_WIDTH-1:0] lim;
        logic                         neg;
        neg = x[DATA_WIDTH-1];
        // A negative clip bound collapses clipped ReLU to all-zero output.
        lim = clip[DATA_WIDTH-1] ? '0 : clip;
        case (m)
            MODE_BYPASS: return x;
            MODE_RELU:   return neg ? '0 : x;
            MODE_LEAKY:  return neg ? (x >>> sh) : x;
            default:     return neg ? '0 : ((x > lim) ? lim : x);
        endcase
    endfunction

    // s2 can take a new beat when empty or when its current beat is leaving this cycle.
    assign s2_load      = !s2_valid_q || act_ready_out;
    assign act_ready_in = !s1_valid_q || s2_load;
    assign in_xfer      = act_valid_in && act_ready_in;

    // NOTE: every output of an always_comb gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        s2_data_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            s2_data_d[k*DATA_WIDTH +: DATA_WIDTH] =
                act_lane(s1_data_q[k*DATA_WIDTH +: DATA_WIDTH], s1_mode_q, s1_shift_q, s1_clip_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= MODE_BYPASS;
            s1_shift_q <= '0;
            s1_clip_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            if (act_ready_in) begin
                s1_valid_q <= act_valid_in;
            end
            if (in_xfer) begin
                s1_data_q  <= act_data_in;
                s1_mode_q  <= mode_e'(act_mode);
                s1_shift_q <= act_leak_shift;
                s1_clip_q  <= act_clip_max;
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s2_data_d;
                end
            end
        end
    end

    assign act_valid_out = s2_valid_q;
    assign act_data_out  = s2_data_q;

endmodule
